// File: rtl/bit_serial_adder.sv
// bit_serial_adder
// ----------------
// Adds two WIDTH-bit operands plus a carry-in by passing one bit per clock
// through a single full_adder cell, LSB first. The carry ripples through a
// one-bit register instead of a chain of cells.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only while idle
//   a, b   - operands, captured on the accepting edge
//   cin    - initial carry, captured on the accepting edge
//   busy   - high whenever an operation is in progress (RUN or DONE)
//   done   - one-cycle pulse marking a fresh result
//   sum    - registered result, held until the next completion
//   cout   - registered final carry, held until the next completion

// One-bit full adder cell that the serial stage time-shares.
module full_adder (
  input  logic augend,
  input  logic addend,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = augend ^ addend ^ carry_in;
  assign carry_out = (augend & addend) | (carry_in & (augend ^ addend));
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  // The lowest bit of the partial-sum shifter would be shifted out on the
  // same edge the final result is taken from sum_step, so it is never read
  // and is not stored.
  logic [WIDTH-1:1] sum_sh_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_step;

  full_adder u_fa (
    .augend    (a_sh_reg[0]),
    .addend    (b_sh_reg[0]),
    .carry_in  (carry_reg),
    .sum       (fa_sum),
    .carry_out (fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at bit 0.
  assign sum_step = {fa_sum, sum_sh_reg[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand shifters, carry, bit counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_sh_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            carry_reg  <= cin;
            cnt_reg    <= '0;
            sum_sh_reg <= '0;
          end
        end
        RUN: begin
          a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
          sum_sh_reg <= sum_step[WIDTH-1:1];
          carry_reg  <= fa_cout;
          cnt_reg    <= cnt_reg + 1'b1;
          // Outputs are only touched on the final bit so they never show
          // a partially built result.
          if (cnt_reg == LAST) begin
            sum_reg  <= sum_step;
            cout_reg <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Testbench for bit_serial_adder: a WIDTH=8 and a WIDTH=2 instance share
// clock and reset. A timeline model predicts busy/done/sum/cout from the
// accepting edge and plain integer addition; a compare process checks both
// instances every cycle, and directed tests add literal expectations.
module tb_bit_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       st[2];
  logic [7:0] av[2];
  logic [7:0] bv[2];
  logic       ci[2];
  logic       busy_o[2];
  logic       done_o[2];
  logic       cout_o[2];
  logic [7:0] sum_o[2];
  logic [1:0] sum2;

  int n_pass  = 0;
  int n_total = 0;
  logic cmp_en = 1'b0;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0]), .b(bv[0]), .cin(ci[0]),
    .busy(busy_o[0]), .done(done_o[0]), .sum(sum_o[0]), .cout(cout_o[0])
  );

  bit_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1][1:0]), .b(bv[1][1:0]), .cin(ci[1]),
    .busy(busy_o[1]), .done(done_o[1]), .sum(sum2), .cout(cout_o[1])
  );
  assign sum_o[1] = {6'b0, sum2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  // An accepted request at edge k raises busy after k, completes with
  // a+b+cin after edge k+W (done for one cycle) and frees the adder after
  // edge k+W+1. Requests arriving while occupied are dropped.
  logic m_active[2];
  int   m_acc[2];
  int   m_val[2];
  logic m_done[2];
  int   m_sum[2];
  logic m_cout[2];
  int   k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
      for (int i = 0; i < 2; i++) begin
        m_active[i] <= 1'b0;
        m_acc[i]    <= 0;
        m_val[i]    <= 0;
        m_done[i]   <= 1'b0;
        m_sum[i]    <= 0;
        m_cout[i]   <= 1'b0;
      end
    end else begin
      k <= k + 1;
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 1'b0;
        if (!m_active[i]) begin
          if (st[i]) begin
            m_active[i] <= 1'b1;
            m_acc[i]    <= k;
            m_val[i]    <= int'(av[i]) + int'(bv[i]) + int'(ci[i]);
          end
        end else if (k == m_acc[i] + wid(i)) begin
          m_sum[i]  <= m_val[i] % (1 << wid(i));
          m_cout[i] <= ((m_val[i] >> wid(i)) & 1) != 0;
          m_done[i] <= 1'b1;
        end else if (k == m_acc[i] + wid(i) + 1) begin
          m_active[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("w%0d_busy", wid(i)), 64'(busy_o[i]), 64'(m_active[i]));
        chk($sformatf("w%0d_done", wid(i)), 64'(done_o[i]), 64'(m_done[i]));
        chk($sformatf("w%0d_sum",  wid(i)), 64'(sum_o[i]),  64'(m_sum[i]));
        chk($sformatf("w%0d_cout", wid(i)), 64'(cout_o[i]), 64'(m_cout[i]));
      end
    end
  end

  // ---------------- done monitor for back-to-back test ----------------
  logic b2b_en = 1'b0;
  int   ncyc = 0;
  int   done_cyc[$];
  int   done_val[$];

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (b2b_en && done_o[0]) begin
      done_cyc.push_back(ncyc);
      done_val.push_back(int'(sum_o[0]) + (int'(cout_o[0]) << 8));
    end
  end

  // One request on instance i; checks latency, result and pulse width.
  task automatic run_add(input int i, input logic [7:0] x, input logic [7:0] y,
                         input logic c, input int expv, input string nm);
    int n;
    int got;
    @(negedge clk);
    st[i] = 1'b1; av[i] = x; bv[i] = y; ci[i] = c;
    @(negedge clk);
    st[i] = 1'b0; av[i] = 8'h00; bv[i] = 8'h00; ci[i] = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done_o[i]) break;
    end
    got = int'(sum_o[i]) + (int'(cout_o[i]) << wid(i));
    chk({nm, "_latency"}, 64'(n), 64'(wid(i)));
    chk({nm, "_result"}, 64'(got), 64'(expv));
    @(negedge clk);
    chk({nm, "_pulse"}, 64'(done_o[i]), 64'd0);
  endtask

  int exp_v[4];
  logic [7:0] op_a[4];
  logic [7:0] op_b[4];

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; av[i] = 8'h00; bv[i] = 8'h00; ci[i] = 1'b0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;

    // Reset then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", 64'(busy_o[0]), 64'd0);
    chk("idle_sum",  64'(sum_o[0]),  64'd0);

    // Basic adds
    run_add(0, 8'h3C, 8'h42, 1'b0, 'h07E, "add_3c_42");
    chk("add1_sum_lit", 64'(sum_o[0]), 64'h7E);

    // Asynchronous reset between edges clears the result at once
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_sum", 64'(sum_o[0]), 64'd0);
    chk("async_rst_busy", 64'(busy_o[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_add(0, 8'hFF, 8'h01, 1'b0, 'h100, "add_ff_01");
    chk("add2_cout_lit", 64'(cout_o[0]), 64'd1);
    run_add(0, 8'hA5, 8'h5A, 1'b1, 'h100, "add_a5_5a_c1");
    chk("add3_sum_lit", 64'(sum_o[0]), 64'h00);

    // Busy protection: start pulses in RUN and in DONE are ignored
    @(negedge clk);
    st[0] = 1'b1; av[0] = 8'h10; bv[0] = 8'h20; ci[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    st[0] = 1'b1; av[0] = 8'hFF; bv[0] = 8'hFF;
    @(negedge clk);
    st[0] = 1'b0;
    n = 0;
    while (n < 40 && !done_o[0]) begin
      @(negedge clk);
      n++;
    end
    chk("busyprot_done_seen", 64'(done_o[0]), 64'd1);
    st[0] = 1'b1; av[0] = 8'hFF; bv[0] = 8'hFF;
    @(negedge clk);
    st[0] = 1'b0;
    chk("busyprot_sum",  64'(sum_o[0]),  64'h30);
    chk("busyprot_cout", 64'(cout_o[0]), 64'd0);
    chk("busyprot_busy", 64'(busy_o[0]), 64'd0);
    repeat (12) @(negedge clk);

    // Mid-run reset aborts the operation
    @(negedge clk);
    st[0] = 1'b1; av[0] = 8'hFF; bv[0] = 8'hFF; ci[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst_sum", 64'(sum_o[0]), 64'd0);
    chk("midrst_cout", 64'(cout_o[0]), 64'd0);
    chk("midrst_busy", 64'(busy_o[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ci[0] = 1'b0;
    repeat (12) @(negedge clk);
    run_add(0, 8'h01, 8'h01, 1'b0, 'h002, "after_rst");

    // Back-to-back with start held high
    op_a[0] = 8'h11; op_b[0] = 8'h22; exp_v[0] = 'h033;
    op_a[1] = 8'h80; op_b[1] = 8'h80; exp_v[1] = 'h100;
    op_a[2] = 8'hF0; op_b[2] = 8'h20; exp_v[2] = 'h110;
    op_a[3] = 8'hFF; op_b[3] = 8'hFF; exp_v[3] = 'h1FE;
    @(negedge clk);
    b2b_en = 1'b1;
    st[0] = 1'b1; ci[0] = 1'b0;
    for (int op = 0; op < 4; op++) begin
      n = 0;
      while (busy_o[0] && n < 40) begin
        @(negedge clk);
        n++;
      end
      av[0] = op_a[op]; bv[0] = op_b[op];
      @(negedge clk);
    end
    st[0] = 1'b0;
    repeat (14) @(negedge clk);
    b2b_en = 1'b0;
    chk("b2b_count", 64'(done_cyc.size()), 64'd4);
    for (int j = 0; j < 4 && j < done_cyc.size(); j++) begin
      chk($sformatf("b2b_val%0d", j), 64'(done_val[j]), 64'(exp_v[j]));
      if (j > 0)
        chk($sformatf("b2b_gap%0d", j), 64'(done_cyc[j] - done_cyc[j-1]), 64'd10);
    end

    // Exhaustive on the 2-bit instance
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++)
          run_add(1, 8'(x), 8'(y), c[0], x + y + c, $sformatf("exh_%0d_%0d_%0d", x, y, c));

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
